serial_add_unit: RTL and testbench

//  Bit-serial adder stage. Feeds two WIDTH-bit operands LSB-first, one bit per clock, into a

---
 rtl/serial_add_unit.sv | 164 ++++++++++++++++
 tb/tb_serial_add_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_unit.sv
// serial_add_unit
//   Bit-serial adder: a single full-adder slice with a registered carry adds
//   two WIDTH-bit operands LSB-first, one bit per clock. The sum bits are
//   reassembled into a parallel result. One add takes WIDTH+2 cycles
//   back-to-back: accept, WIDTH shift cycles, one done cycle.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 2)
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      synchronous active-high reset
//   start      request, sampled only while idle
//   a, b       operands, captured on the accepted start
//   carry_in   initial carry, captured on the accepted start
//   busy       high while shifting
//   done       one-cycle pulse when sum/carry_out/overflow are fresh
//   sum        result, held until the next done
//   carry_out  final carry, held with sum
//   overflow   signed overflow of the add, held with sum
//
// Configuration macro
//   SERIAL_ADD_OVERFLOW_EN  defined: overflow is registered as carry-into-MSB
//                           XOR carry-out-of-MSB; undefined: overflow tied 0.

module serial_add_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds only the upper WIDTH-1 bits of the sum shift register; its
    // lowest bit would never be read, so it is not stored.
    logic [WIDTH-2:0] s_sh_q, s_sh_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;

    logic             slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] s_next;
    logic             msb_cycle;

    assign slice_sum  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign slice_cout = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
    assign s_next     = {slice_sum, s_sh_q};
    assign msb_cycle  = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        s_sh_d      = s_sh_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = carry_in;
                    cnt_d   = '0;
                    s_sh_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                s_sh_d = s_next[WIDTH-1:1];
                c_d    = slice_cout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (msb_cycle) begin
                    sum_d       = s_next;
                    carry_out_d = slice_cout;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            s_sh_q      <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            s_sh_q      <= s_sh_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
        end
    end

`ifdef SERIAL_ADD_OVERFLOW_EN
    logic overflow_q, overflow_d;

    // c_q is the carry into the MSB during the MSB cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (msb_cycle) begin
            overflow_d = c_q ^ slice_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// tb_serial_add_unit
//   Directed bench for serial_add_unit (WIDTH=8). Stimulus pushes the expected
//   {overflow, carry_out, sum} of each accepted add into a queue; a monitor
//   pops and compares whenever done is high.

module tb_serial_add_unit;

    localparam int unsigned WIDTH = 8;

`ifdef SERIAL_ADD_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    int n_checks;
    int n_fail;

    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] exp_e;

    serial_add_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                exp_e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(exp_e[WIDTH-1:0]));
                check("carry_out", 32'(carry_out), 32'(exp_e[WIDTH]));
                check("overflow", 32'(overflow), 32'(exp_e[WIDTH+1]));
            end
        end
    end

    // Issue one add, check busy, latency to done, and single-cycle done pulse.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        carry_in = tc;
        start    = 1'b1;
        exp_q.push_back({eo & OVF_EN, ec, es});
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(WIDTH));
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("sum_hold", 32'(sum), 32'(es));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b1;
        a        = 8'h55;
        b        = 8'h33;
        carry_in = 1'b1;

        // Reset held two cycles with start asserted
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_sum", 32'(sum), 32'd0);
            check("rst_cout", 32'(carry_out), 32'd0);
            check("rst_ovf", 32'(overflow), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_rst", 32'(busy), 32'd0);

        // Directed vectors: a, b, cin -> sum, cout, signed overflow
        do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        do_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        do_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

        // Starts during SHIFT (edge 3) and DONE (edge 9) are ignored
        @(negedge clk);
        a        = 8'h03;
        b        = 8'h04;
        carry_in = 1'b0;
        start    = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 8'h07});
        @(posedge clk);          // edge 0
        #1;
        start = 1'b0;
        a     = 8'hAA;
        repeat (2) @(posedge clk); // edges 1, 2
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);          // edge 3
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk); // edges 4..8
        #1;
        check("t5_done", 32'(done), 32'd1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);          // edge 9
        #1;
        start = 1'b0;
        check("t5_not_accepted", 32'(busy), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("t5_sum_hold", 32'(sum), 32'h07);

        // Reset mid-operation aborts without done and clears results
        @(negedge clk);
        a     = 8'h11;
        b     = 8'h22;
        start = 1'b1;
        @(posedge clk);          // edge 0
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk); // edges 1..3
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);          // edge 4
        #1;
        reset = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_sum", 32'(sum), 32'd0);
        check("t6_cout", 32'(carry_out), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("t6_still_idle", 32'(busy), 32'd0);

        do_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
